// File: rtl/uart_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART TX arbiter and its round-robin selector.
//   ID_W        : width of a requester index (supports up to 8 requesters)
//   arb_state_t : arbiter FSM encoding (IDLE / GRANT / RELEASE)
//   rr_next()   : next index in an 8-bit mask, searching upward from last+1
// Optional feature macro used by the arbiter top: UART_TX_ARB_PRIO0_EN.
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Searches last+1, last+2, ... wrapping modulo 8. Callers zero-pad the mask
  // above their requester count; since last is always a valid index, wrapping
  // modulo 8 over a zero-padded mask equals wrapping modulo the real count.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] last,
                                              input logic [7:0]      mask);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] res;
    logic            found;
    res   = '0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + ID_W'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Purely combinational round-robin selector. Picks the first set bit of mask
// searching upward from last_grant+1, wrapping modulo NUM_REQ.
// Ports:
//   mask       in  NUM_REQ  candidate requests
//   last_grant in  ID_W     index that won most recently (lowest priority now)
//   sel        out ID_W     selected index (0 when mask is empty)
//   any        out 1        at least one mask bit is set
// -----------------------------------------------------------------------------
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    sel,
  output logic               any
);

  logic [7:0] w_mask8;

  always_comb begin
    w_mask8                = '0;
    w_mask8[NUM_REQ-1:0]   = mask;
  end

  assign sel = rr_next(last_grant, w_mask8);
  assign any = |mask;

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter sharing the UART TX FIFO write port between NUM_REQ
// byte-stream requesters. A grant is held for a whole message (until req_last),
// for at most MAX_BURST bytes, or until the holder has been idle GAP_MAX
// cycles, so messages from different sources never interleave.
//
// Optional feature (macro UART_TX_ARB_PRIO0_EN): requester 0 always wins
// arbitration when valid, and a grant held by another requester is released
// after its current transfer once requester 0 is valid.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           arbiter enable; low blocks new grants only
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester i at [8i+7:8i]
//   req_last     byte is the last of its message
//   req_ready    per-requester accept (valid & ready = byte taken)
//   tx_full      TX FIFO full
//   tx_wr_en     TX FIFO push strobe
//   tx_wdata     TX FIFO push data
//   grant_valid  a requester holds the grant
//   grant_id     index of the granted requester
//   burst_cnt    bytes transferred in the current grant
//   dbg_state    arbiter FSM state (IDLE=0, GRANT=1, RELEASE=2)
//
// Handshake: a byte moves on a rising clk edge exactly when req_valid[i] and
// req_ready[i] are both high. req_ready is only ever high for the granted
// requester in GRANT and only while tx_full is low; tx_wr_en/tx_wdata mirror
// that same cycle combinationally, so the FIFO push and the requester accept
// are the same event.
// -----------------------------------------------------------------------------
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int GAP_MAX   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_full,
  output logic                 tx_wr_en,
  output logic [7:0]           tx_wdata,
  output logic                 grant_valid,
  output logic [2:0]           grant_id,
  output logic [7:0]           burst_cnt,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_GRANT   = GRANT;
  localparam logic [1:0] S_RELEASE = RELEASE;

  logic [1:0]      r_state;
  logic            r_grant_valid;
  logic [ID_W-1:0] r_grant_id;
  logic [ID_W-1:0] r_last_grant;
  logic [7:0]      r_burst_cnt;
  logic [7:0]      r_gap_cnt;

  logic [ID_W-1:0] w_rr_sel;
  logic [ID_W-1:0] w_sel;
  logic            w_any;
  logic            w_in_grant;
  logic            w_gnt_valid;
  logic            w_gnt_last;
  logic [7:0]      w_gnt_data;
  logic            w_burst_hit;
  logic            w_gap_hit;
  logic            w_prio_rel;

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .mask      (req_valid),
    .last_grant(r_last_grant),
    .sel       (w_rr_sel),
    .any       (w_any)
  );

`ifdef UART_TX_ARB_PRIO0_EN
  assign w_sel      = req_valid[0] ? '0 : w_rr_sel;
  // Early release lets requester 0 in at the next byte boundary.
  assign w_prio_rel = req_valid[0] && (r_grant_id != '0);
`else
  assign w_sel      = w_rr_sel;
  assign w_prio_rel = 1'b0;
`endif

  assign w_in_grant = (r_state == S_GRANT);

  // Mux the granted requester's lane; loop compare avoids an index wider
  // than the request vectors.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_last  = 1'b0;
    w_gnt_data  = '0;
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_gnt_valid  = req_valid[i];
        w_gnt_last   = req_last[i];
        w_gnt_data   = req_data[8*i +: 8];
        req_ready[i] = w_in_grant & ~tx_full;
      end
    end
  end

  assign tx_wr_en    = w_in_grant & w_gnt_valid & ~tx_full;
  assign tx_wdata    = tx_wr_en ? w_gnt_data : 8'h00;

  assign w_burst_hit = (r_burst_cnt + 8'd1) == 8'(MAX_BURST);
  assign w_gap_hit   = (r_gap_cnt == 8'(GAP_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_last_grant  <= ID_W'(NUM_REQ - 1);
      r_burst_cnt   <= '0;
      r_gap_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en && w_any) begin
            r_state       <= S_GRANT;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_sel;
            r_burst_cnt   <= '0;
            r_gap_cnt     <= '0;
          end
        end
        S_GRANT: begin
          if (tx_wr_en) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
            r_gap_cnt   <= '0;
            // last and burst limit on the same byte collapse into one release
            if (w_gnt_last || w_burst_hit || w_prio_rel) begin
              r_state       <= S_RELEASE;
              r_grant_valid <= 1'b0;
            end
          end else if (!w_gnt_valid) begin
            // A stall on tx_full never counts as idle; only absent data does.
            if (w_gap_hit) begin
              r_state       <= S_RELEASE;
              r_grant_valid <= 1'b0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 8'd1;
            end
          end
        end
        S_RELEASE: begin
          r_last_grant <= r_grant_id;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state       <= S_IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign burst_cnt   = r_burst_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
// Self-checking bench for uart_tx_arb (default build, round-robin only).
// Requester models replay per-source byte lists; every FIFO push is compared
// against an expected queue of {grant_id, byte} filled in arbitration order.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 8;
  localparam int GAP_MAX   = 16;
  localparam int W         = 11;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_full;
  logic                 tx_wr_en;
  logic [7:0]           tx_wdata;
  logic                 grant_valid;
  logic [2:0]           grant_id;
  logic [7:0]           burst_cnt;
  logic [1:0]           dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [8:0]   src_mem[NUM_REQ][128];
  int           src_wr[NUM_REQ] = '{default: 0};
  int           src_rd[NUM_REQ] = '{default: 0};

  uart_tx_arb #(
    .NUM_REQ  (NUM_REQ),
    .MAX_BURST(MAX_BURST),
    .GAP_MAX  (GAP_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_full    (tx_full),
    .tx_wr_en   (tx_wr_en),
    .tx_wdata   (tx_wdata),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .burst_cnt  (burst_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input int r, input int n, input logic [7:0] base, input bit last_end);
    for (int i = 0; i < n; i++) begin
      src_mem[r][src_wr[r]] = {(last_end && (i == n - 1)), 8'(base + 8'(i))};
      src_wr[r]++;
    end
  endtask

  task automatic expect_bytes(input int r, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++)
      exp_q.push_back({3'(r), 8'(base + 8'(i))});
  endtask

  task automatic flush_src();
    for (int r = 0; r < NUM_REQ; r++) src_rd[r] = src_wr[r];
  endtask

  function automatic bit src_busy();
    bit b = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) if (src_rd[r] < src_wr[r]) b = 1'b1;
    return b;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    tx_full = 1'b0;
    flush_src();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (k < 400 && (exp_q.size() != 0 || src_busy() || grant_valid || dbg_state != ST_IDLE)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_drain_timeout"}, 32'(k >= 400), 32'd0);
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Requester models: sample the handshake mid-cycle, advance after the edge.
  initial begin
    logic [NUM_REQ-1:0] fire;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (fire[r] && src_rd[r] < src_wr[r]) src_rd[r]++;
        if (src_rd[r] < src_wr[r]) begin
          req_valid[r] = 1'b1;
          {req_last[r], req_data[8*r +: 8]} = src_mem[r][src_rd[r]];
        end else begin
          req_valid[r]         = 1'b0;
          req_last[r]          = 1'b0;
          req_data[8*r +: 8]   = 8'h00;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (tx_wr_en === 1'b1) begin
        chk("push_expected", 32'(tx_wr_en), 32'(exp_q.size() != 0));
        chk("push_while_full", 32'(tx_full), 32'd0);
        if (exp_q.size() != 0)
          chk("push_data", 32'({grant_id, tx_wdata}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bit bad_wr, bad_rdy, bad_hold;

    // Reset values
    rst_n = 1'b0; en = 1'b1; tx_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gv",    32'(grant_valid), 32'd0);
    chk("rst_gid",   32'(grant_id),    32'd0);
    chk("rst_burst", 32'(burst_cnt),   32'd0);
    chk("rst_wr",    32'(tx_wr_en),    32'd0);
    chk("rst_wdata", 32'(tx_wdata),    32'd0);
    chk("rst_ready", 32'(req_ready),   32'd0);
    chk("rst_state", 32'(dbg_state),   32'(ST_IDLE));
    rst_n = 1'b1;

    // S1: single 3-byte message from requester 0, cycle-exact
    #1;
    load(0, 1, 8'h11, 0); load(0, 1, 8'h22, 0); load(0, 1, 8'h33, 1);
    expect_bytes(0, 1, 8'h11); expect_bytes(0, 1, 8'h22); expect_bytes(0, 1, 8'h33);
    @(negedge clk);
    chk("s1_idle_gv",  32'(grant_valid), 32'd0);
    chk("s1_idle_wr",  32'(tx_wr_en),    32'd0);
    @(negedge clk);
    chk("s1_gv",       32'(grant_valid), 32'd1);
    chk("s1_gid",      32'(grant_id),    32'd0);
    chk("s1_state",    32'(dbg_state),   32'(ST_GRANT));
    chk("s1_ready",    32'(req_ready),   32'b0001);
    chk("s1_burst0",   32'(burst_cnt),   32'd0);
    @(negedge clk);
    chk("s1_burst1",   32'(burst_cnt),   32'd1);
    @(negedge clk);
    chk("s1_burst2",   32'(burst_cnt),   32'd2);
    @(negedge clk);
    chk("s1_rel_state", 32'(dbg_state),  32'(ST_RELEASE));
    chk("s1_rel_gv",   32'(grant_valid), 32'd0);
    chk("s1_rel_burst", 32'(burst_cnt),  32'd3);
    chk("s1_rel_ready", 32'(req_ready),  32'd0);
    @(negedge clk);
    chk("s1_idle_after", 32'(dbg_state), 32'(ST_IDLE));
    drain("s1");

    // S2: four requesters, 2-byte messages, order 0,1,2,3,0
    do_reset();
    #1;
    load(0, 2, 8'hA0, 1); load(1, 2, 8'hB0, 1); load(2, 2, 8'hC0, 1);
    load(3, 2, 8'hD0, 1); load(0, 2, 8'hA2, 1);
    expect_bytes(0, 2, 8'hA0); expect_bytes(1, 2, 8'hB0); expect_bytes(2, 2, 8'hC0);
    expect_bytes(3, 2, 8'hD0); expect_bytes(0, 2, 8'hA2);
    drain("s2");

    // S3: requester 2 streams 20 bytes without last; burst limit hands over to 3
    #1;
    load(2, 20, 8'h40, 0); load(3, 2, 8'hE0, 1);
    expect_bytes(2, 8, 8'h40); expect_bytes(3, 2, 8'hE0);
    expect_bytes(2, 8, 8'h48); expect_bytes(2, 4, 8'h50);
    k = 0;
    while (dbg_state != ST_RELEASE && k < 100) begin @(negedge clk); k++; end
    chk("s3_rel_seen", 32'(k < 100), 32'd1);
    chk("s3_rel_gid",  32'(grant_id), 32'd2);
    chk("s3_rel_burst", 32'(burst_cnt), 32'(MAX_BURST));
    k = 0;
    while (!grant_valid && k < 20) begin @(negedge clk); k++; end
    chk("s3_next_gid", 32'(grant_id), 32'd3);
    drain("s3");

    // S4: tx_full held 50 cycles mid-message
    #1;
    load(1, 6, 8'h60, 1);
    expect_bytes(1, 6, 8'h60);
    k = 0;
    while (!(grant_valid && grant_id == 3'd1 && burst_cnt == 8'd2) && k < 50) begin
      @(negedge clk); k++;
    end
    chk("s4_reach", 32'(k < 50), 32'd1);
    #1 tx_full = 1'b1;
    #1;
    bad_wr = 0; bad_rdy = 0; bad_hold = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_wr_en !== 1'b0) bad_wr = 1;
      if (req_ready !== '0) bad_rdy = 1;
      if (grant_valid !== 1'b1) bad_hold = 1;
      @(negedge clk);
    end
    chk("s4_no_push",  32'(bad_wr),   32'd0);
    chk("s4_ready_lo", 32'(bad_rdy),  32'd0);
    chk("s4_held",     32'(bad_hold), 32'd0);
    chk("s4_burst",    32'(burst_cnt), 32'd2);
    #1 tx_full = 1'b0;
    #1;
    chk("s4_resume",   32'(tx_wr_en), 32'd1);
    chk("s4_ready",    32'(req_ready), 32'b0010);
    drain("s4");

    // S5: granted requester goes idle -> release after exactly GAP_MAX idle cycles
    #1;
    load(3, 2, 8'h70, 0);
    expect_bytes(3, 2, 8'h70);
    k = 0;
    while (!(grant_valid && grant_id == 3'd3 && burst_cnt == 8'd2) && k < 50) begin
      @(negedge clk); k++;
    end
    chk("s5_reach", 32'(k < 50), 32'd1);
    k = 0;
    while (grant_valid && k < 100) begin @(negedge clk); k++; end
    chk("s5_gap_len", 32'(k), 32'(GAP_MAX));
    chk("s5_state",   32'(dbg_state), 32'(ST_RELEASE));
    drain("s5");

    // S6: last on the MAX_BURST-th byte -> single release
    #1;
    load(1, 8, 8'h80, 1); load(1, 1, 8'h90, 1);
    expect_bytes(1, 8, 8'h80); expect_bytes(1, 1, 8'h90);
    k = 0;
    while (dbg_state != ST_RELEASE && k < 50) begin @(negedge clk); k++; end
    chk("s6_rel_burst", 32'(burst_cnt), 32'(MAX_BURST));
    @(negedge clk);
    chk("s6_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    chk("s6_regrant", 32'({grant_valid, grant_id, burst_cnt}), 32'({1'b1, 3'd1, 8'd0}));
    drain("s6");

    // S7: en low blocks new grants but lets the current one finish
    #1;
    en = 1'b0;
    load(2, 3, 8'hA8, 1);
    repeat (6) @(negedge clk);
    chk("s7_blocked", 32'(grant_valid), 32'd0);
    expect_bytes(2, 3, 8'hA8);
    #1 en = 1'b1;
    k = 0;
    while (!grant_valid && k < 10) begin @(negedge clk); k++; end
    chk("s7_gid", 32'(grant_id), 32'd2);
    #1 en = 1'b0;
    load(0, 1, 8'hB8, 1);
    repeat (12) @(negedge clk);
    chk("s7_done",    32'(exp_q.size()), 32'd0);
    chk("s7_no_new",  32'(grant_valid),  32'd0);
    expect_bytes(0, 1, 8'hB8);
    #1 en = 1'b1;
    drain("s7");

    // S8: asynchronous reset mid-grant after 2 bytes
    #1;
    load(2, 4, 8'hC8, 1);
    expect_bytes(2, 2, 8'hC8);
    k = 0;
    while (!(grant_valid && grant_id == 3'd2 && burst_cnt == 8'd2) && k < 50) begin
      @(posedge clk); #2; k++;
    end
    chk("s8_reach", 32'(k < 50), 32'd1);
    rst_n = 1'b0;
    flush_src();
    #1;
    chk("s8_gv",    32'(grant_valid), 32'd0);
    chk("s8_gid",   32'(grant_id),    32'd0);
    chk("s8_burst", 32'(burst_cnt),   32'd0);
    chk("s8_wr",    32'(tx_wr_en),    32'd0);
    chk("s8_wdata", 32'(tx_wdata),    32'd0);
    chk("s8_ready", 32'(req_ready),   32'd0);
    chk("s8_state", 32'(dbg_state),   32'(ST_IDLE));
    chk("s8_sb",    32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    load(3, 1, 8'hD8, 1); load(0, 1, 8'hD0, 1);
    expect_bytes(0, 1, 8'hD0); expect_bytes(3, 1, 8'hD8);
    k = 0;
    while (!grant_valid && k < 10) begin @(negedge clk); k++; end
    chk("s8_first_gid", 32'(grant_id), 32'd0);
    drain("s8");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares the single UART transmit path (TX FIFO → Tx_FSM → shift register) between NUM_REQ byte-stream requesters.
- Grants one requester at a time and holds the grant for a whole message (until `req_last`) or for at most MAX_BURST bytes, so frames from different sources never interleave mid-message.
- Sits between the requesters and the TX FIFO write port. Back-pressure comes from the FIFO `tx_full` flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MAX_BURST, 8, maximum bytes per grant before forced release (1..255)
- GAP_MAX, 16, consecutive idle cycles (granted requester not valid) before forced release (1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbiter enable; low blocks new grants only
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is last of message
- req_ready  out  NUM_REQ  byte accepted when valid&ready
- tx_full  in  1  TX FIFO full
- tx_wr_en  out  1  TX FIFO push strobe
- tx_wdata  out  8  TX FIFO push data
- grant_valid  out  1  a requester currently holds the grant
- grant_id  out  3  index of granted requester
- burst_cnt  out  8  bytes transferred in current grant

Behaviour:
- Reset values:
  - state = IDLE; grant_valid = 0; grant_id = 0; burst_cnt = 0; gap_cnt = 0.
  - last_grant = NUM_REQ-1, so that requester 0 wins first.
  - req_ready = 0; tx_wr_en = 0; tx_wdata = 0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If en=1 and any req_valid, select the first valid index searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Next cycle: state = GRANT, grant_valid = 1, grant_id = selected index, burst_cnt = 0, gap_cnt = 0.
  - Arbitration latency is one cycle; no byte moves in IDLE.
- GRANT:
  - req_ready[grant_id] = ~tx_full (combinational); all other req_ready bits are 0.
  - Transfer occurs when req_valid[grant_id] & ~tx_full.
  - On a transfer: tx_wr_en = 1 and tx_wdata = req_data[grant_id], same cycle (combinational path); burst_cnt increments; gap_cnt clears.
  - Release condition: the transfer carries req_last, or burst_cnt+1 == MAX_BURST. On release, next state = RELEASE.
  - tx_full=1 while valid: stall. No transfer, gap_cnt not incremented, grant held indefinitely.
  - req_valid[grant_id]=0: gap_cnt increments. When gap_cnt reaches GAP_MAX-1 and the requester is still not valid, next state = RELEASE.
- RELEASE (one cycle):
  - last_grant = grant_id; grant_valid = 0; req_ready = 0.
  - Next state = IDLE, so every grant is followed by at least one dead cycle.
- Fairness: the requester just released gets lowest priority at the next arbitration.
- en deasserted during GRANT: the current grant completes normally; no new grant is issued while en=0.
- Simultaneous req_last and MAX_BURST on the same transfer: a single release.
- Counters never wrap: burst_cnt ≤ MAX_BURST-1 before release; gap_cnt saturates.
- Asynchronous reset mid-grant: all outputs return to reset values immediately. A partial message is abandoned; no byte is pushed after reset asserts.
- grant_id upper bits beyond clog2(NUM_REQ) are 0.

Optional Feature:
- Macro: UART_TX_ARB_PRIO0_EN.
- Defined: requester 0 is high priority.
  - In IDLE, if req_valid[0]=1 it always wins, regardless of last_grant.
  - An ongoing grant to another requester is not pre-empted, but is released after its current transfer once req_valid[0] is seen (early release, counted as a normal release).
- Undefined: pure round-robin as above.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - localparam ID_W = 3;
  - a function rr_next(last, mask) returning the next index.
- Natural sub-module: uart_rr_pick. Purely combinational round-robin/priority selector with inputs mask and last_grant and outputs sel and any; reused by the future RX distribution logic.

Test Plan:
- Reset, then req_valid=4'b0001, 3 bytes 0x11,0x22,0x33 with last on 0x33:
  - grant_id=0 one cycle after request;
  - tx_wr_en pulses with 0x11,0x22,0x33;
  - RELEASE then IDLE; burst_cnt=3 before release.
- All four requesters valid with 2-byte messages each → grants in order 0,1,2,3,0. No interleaving of bytes on tx_wdata.
- Requester 2 streams 20 bytes with no last, MAX_BURST=8:
  - released after 8 bytes; requester 3 (if valid) is granted next;
  - requester 2 regains the grant later and continues at byte 9.
- tx_full held high for 50 cycles mid-message:
  - no tx_wr_en and req_ready=0 throughout;
  - grant retained; resumes on the first cycle tx_full=0.
- Granted requester drops valid for GAP_MAX cycles → forced release after exactly GAP_MAX idle cycles; grant_valid=0.
- rst_n asserted mid-GRANT after 2 bytes → outputs zero immediately; after reset, requester 0 wins first. With UART_TX_ARB_PRIO0_EN defined, requester 0 pre-empts at the next byte boundary.
